sweep_stim: RTL and testbench
=============================

SWEEP_STIM -- requirements
Module: sweep_stim

Interface
REQ-001 SHALL have parameter WIDTH, default 16: argument/result width in bits.
REQ-002 SHALL have parameter MAX, default 24: largest argument issued; MAX < 2^WIDTH.
REQ-003 SHALL have parameter DIV_W, default 27: auto-mode divider width in bits.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port sw, input, WIDTH: manual argument from switches (asynchronous).
REQ-007 SHALL have port mode, input, 2: 00 MANUAL, 01 AUTO, 10 STEP, 11 HOLD.
REQ-008 SHALL have port step, input, 1: asynchronous step button.
REQ-009 SHALL have port dut_in, output, WIDTH: argument to the DUT.
REQ-010 SHALL have port dut_in_valid, output, 1: argument valid.
REQ-011 SHALL have port dut_in_ready, input, 1: DUT accepts argument.
REQ-012 SHALL have port dut_out, input, WIDTH: DUT result.
REQ-013 SHALL have port dut_out_valid, input, 1: result valid.
REQ-014 SHALL have port dut_out_ready, output, 1: block accepts result.
REQ-015 SHALL have port result, output, WIDTH: last captured result.
REQ-016 SHALL have port cur, output, WIDTH: last issued argument.
REQ-017 SHALL have port overrun, output, 8: saturating count of dropped triggers.

Function
REQ-018 SHALL pass sw and step through two-flop synchronisers before use; step trigger = rising edge of synchronised step.
REQ-019 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-020 IDLE: when trigger fires, SHALL load cur with next argument and enter REQ; dut_in_valid rises the cycle after the trigger.
REQ-021 REQ: dut_in_valid=1 and dut_in=cur held stable until dut_in_valid&&dut_in_ready, then enter WAIT.
REQ-022 WAIT: dut_out_ready=1; on dut_out_valid&&dut_out_ready, result<=dut_out and enter IDLE.
REQ-023 dut_in_valid SHALL be 1 only in REQ; dut_out_ready SHALL be 1 only in WAIT.
REQ-024 MANUAL trigger: synchronised sw != cur and sw <= MAX; next argument = sw; sw > MAX never triggers.
REQ-025 AUTO: div (DIV_W bits) increments every cycle, wraps; trigger when div==0; next argument = (cur==MAX) ? 0 : cur+1.
REQ-026 div SHALL be held at 0 outside AUTO, so the first AUTO trigger occurs on the first cycle in AUTO.
REQ-027 STEP: trigger on step rising edge; next argument as in AUTO.
REQ-028 HOLD: no triggers; an in-flight transaction completes normally.
REQ-029 AUTO or STEP trigger arising in REQ or WAIT SHALL be dropped and increment overrun, saturating at 255; MANUAL trigger conditions persist and are re-evaluated in IDLE.
REQ-030 Mode change mid-transaction SHALL NOT abort it; the new mode applies from the next IDLE cycle.
REQ-031 A DUT accepting and answering in the same cycle still takes REQ then WAIT; a result is captured only in WAIT.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, cur=0, result=0, div=0, overrun=0, dut_in_valid=0, dut_out_ready=0, synchroniser flops=0, regardless of clk.
REQ-033 Reset mid-transaction SHALL abandon it; after release, a MANUAL trigger with sw=0 SHALL NOT fire (sw == cur).

Verification (WIDTH=8, MAX=4, DIV_W=3, DUT result = 2*arg, 1-cycle ready/valid)
REQ-034 MANUAL, sw 0->3 -> one request dut_in=3, result=6, cur=3; sw=9 -> no request.
REQ-035 AUTO for 48 cycles from cur=0 -> arguments 1,2,3,4,0,1 at 8-cycle spacing; overrun=0.
REQ-036 AUTO with dut_in_ready held low 20 cycles -> dut_in stable, valid high throughout, overrun=2.
REQ-037 STEP, three separate step pulses -> arguments 1,2,3; pulse during WAIT -> dropped, overrun+1.
REQ-038 rst_n asserted during WAIT -> all outputs 0 asynchronously; after release, sw=0 issues nothing.
REQ-039 Switch to HOLD during REQ -> transaction completes, result updated, no further requests.

Source files
------------

// File: rtl/sweep_stim.sv
// sweep_stim: stimulus generator that feeds arguments to an attached DUT over
// a ready/valid pair and captures the DUT's result.
//
// Argument sources, selected by mode:
//   00 MANUAL - the switch value, issued whenever it changes to a legal value
//   01 AUTO   - a 0..MAX sweep, one step every 2^DIV_W cycles
//   10 STEP   - a 0..MAX sweep, one step per step-button press
//   11 HOLD   - nothing new is issued
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   sw[WIDTH]                   manual argument (asynchronous switches)
//   mode[2]                     source select (see above)
//   step                        asynchronous step button
//   dut_in/_valid/_ready        argument channel to the DUT
//   dut_out/_valid/_ready       result channel from the DUT
//   result[WIDTH]               last captured result
//   cur[WIDTH]                  last issued argument
//   overrun[8]                  saturating count of dropped AUTO/STEP triggers
module sweep_stim #(
    parameter int WIDTH = 16,
    parameter int MAX   = 24,
    parameter int DIV_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       mode,
    input  logic             step,
    output logic [WIDTH-1:0] dut_in,
    output logic             dut_in_valid,
    input  logic             dut_in_ready,
    input  logic [WIDTH-1:0] dut_out,
    input  logic             dut_out_valid,
    output logic             dut_out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] cur,
    output logic [7:0]       overrun
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    localparam logic [1:0]       MODE_MANUAL = 2'b00;
    localparam logic [1:0]       MODE_AUTO   = 2'b01;
    localparam logic [1:0]       MODE_STEP   = 2'b10;
    localparam logic [WIDTH-1:0] MAX_V       = WIDTH'(MAX);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cur_q, cur_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [7:0]         overrun_q, overrun_d;
    logic               dut_in_valid_q, dut_in_valid_d;
    logic               dut_out_ready_q, dut_out_ready_d;

    // Two-flop synchronisers; step keeps a third flop for edge detection.
    logic [WIDTH-1:0]   sw_s1_q, sw_s2_q;
    logic               step_s1_q, step_s2_q, step_s3_q;

    logic [WIDTH-1:0]   next_arg;
    logic               seq_trig;   // AUTO/STEP trigger: droppable
    logic               man_trig;   // MANUAL trigger: a level, so it persists

    always_comb begin
        next_arg = (cur_q == MAX_V) ? '0 : cur_q + WIDTH'(1);
        // The divider sits at zero outside AUTO so entering AUTO fires at once.
        div_d    = (mode == MODE_AUTO) ? div_q + DIV_W'(1) : '0;
        seq_trig = ((mode == MODE_AUTO) && (div_q == '0)) ||
                   ((mode == MODE_STEP) && step_s2_q && !step_s3_q);
        man_trig = (mode == MODE_MANUAL) && (sw_s2_q != cur_q) && (sw_s2_q <= MAX_V);

        state_d   = state_q;
        cur_d     = cur_q;
        result_d  = result_q;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (seq_trig) begin
                    cur_d   = next_arg;
                    state_d = ST_REQ;
                end else if (man_trig) begin
                    cur_d   = sw_s2_q;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (dut_in_valid_q && dut_in_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Result is only ever captured here, even if the DUT had it
                // ready in the same cycle it accepted the argument.
                if (dut_out_valid && dut_out_ready_q) begin
                    result_d = dut_out;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && seq_trig && (overrun_q != 8'hFF))
            overrun_d = overrun_q + 8'd1;

        // Handshake outputs are registered decodes of the next state.
        dut_in_valid_d  = (state_d == ST_REQ);
        dut_out_ready_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cur_q           <= '0;
            result_q        <= '0;
            div_q           <= '0;
            overrun_q       <= '0;
            dut_in_valid_q  <= 1'b0;
            dut_out_ready_q <= 1'b0;
            sw_s1_q         <= '0;
            sw_s2_q         <= '0;
            step_s1_q       <= 1'b0;
            step_s2_q       <= 1'b0;
            step_s3_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_q           <= cur_d;
            result_q        <= result_d;
            div_q           <= div_d;
            overrun_q       <= overrun_d;
            dut_in_valid_q  <= dut_in_valid_d;
            dut_out_ready_q <= dut_out_ready_d;
            sw_s1_q         <= sw;
            sw_s2_q         <= sw_s1_q;
            step_s1_q       <= step;
            step_s2_q       <= step_s1_q;
            step_s3_q       <= step_s2_q;
        end
    end

    assign dut_in        = cur_q;
    assign dut_in_valid  = dut_in_valid_q;
    assign dut_out_ready = dut_out_ready_q;
    assign result        = result_q;
    assign cur           = cur_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_sweep_stim.sv
module tb_sweep_stim;

    localparam int W   = 8;
    localparam int MX  = 4;
    localparam int DW  = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] sw = '0;
    logic [1:0]   mode = 2'b00;
    logic         step = 1'b0;
    logic [W-1:0] dut_in, dut_out, result, cur;
    logic         dut_in_valid, dut_in_ready, dut_out_valid, dut_out_ready;
    logic [7:0]   overrun;

    sweep_stim #(.WIDTH(W), .MAX(MX), .DIV_W(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .step(step),
        .dut_in(dut_in), .dut_in_valid(dut_in_valid), .dut_in_ready(dut_in_ready),
        .dut_out(dut_out), .dut_out_valid(dut_out_valid), .dut_out_ready(dut_out_ready),
        .result(result), .cur(cur), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached DUT model: result = 2*arg, answered the cycle after acceptance.
    logic         in_ready_en = 1'b1;
    logic         out_en = 1'b1;
    logic         out_pend;
    logic [W-1:0] out_data;
    logic [W-1:0] iss_q[$];
    int           iss_cyc[$];

    assign dut_in_ready  = in_ready_en;
    assign dut_out_valid = out_pend & out_en;
    assign dut_out       = out_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pend <= 1'b0;
            out_data <= '0;
        end else begin
            if (dut_out_valid && dut_out_ready) out_pend <= 1'b0;
            if (dut_in_valid && dut_in_ready) begin
                out_pend <= 1'b1;
                out_data <= W'(2 * dut_in);
                iss_q.push_back(dut_in);
                iss_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        iss_q.delete();
        iss_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sw    = '0;
        step  = 1'b0;
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        clear_log();
    endtask

    task automatic pulse_step(input int low_cycles);
        step = 1'b1;
        tick(4);
        step = 1'b0;
        tick(low_cycles);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({dut_in, dut_in_valid, dut_out_ready, result, cur, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_async: outs=%h want 0",
                     {dut_in, dut_in_valid, dut_out_ready, result, cur, overrun});
        end
        tick(3);
        n_vec++;
        if ({dut_in_valid, dut_out_ready, cur, result, overrun} !== '0) begin
            n_err++;
            $display("FAIL reset_clocked: outs=%h want 0",
                     {dut_in_valid, dut_out_ready, cur, result, overrun});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        clear_log();
    endtask

    task automatic test_manual();
        logic [W-1:0] m_cur, m_res, v;
        mode = 2'b00;
        sw = 8'd3;
        tick(12);
        n_vec++;
        if (iss_q.size() != 1 || iss_q[0] !== 8'd3) begin
            n_err++;
            $display("FAIL manual_issue: n=%0d first=%0d want n=1 arg=3", iss_q.size(),
                     iss_q.size() > 0 ? iss_q[0] : 8'd0);
        end
        n_vec++;
        if (result !== 8'd6 || cur !== 8'd3) begin
            n_err++;
            $display("FAIL manual_result: result=%0d cur=%0d want 6/3", result, cur);
        end
        clear_log();
        sw = 8'd9;
        tick(12);
        n_vec++;
        if (iss_q.size() != 0 || cur !== 8'd3) begin
            n_err++;
            $display("FAIL manual_over_max: n=%0d cur=%0d want 0/3", iss_q.size(), cur);
        end
        m_cur = 8'd3;
        m_res = 8'd6;
        for (int i = 0; i < 12; i++) begin
            clear_log();
            v = W'($urandom_range(0, 7));
            sw = v;
            tick(12);
            n_vec++;
            if (v <= MX && v != m_cur) begin
                m_cur = v;
                m_res = W'(2 * v);
                if (iss_q.size() != 1 || iss_q[0] !== v) begin
                    n_err++;
                    $display("FAIL manual_rand_issue: sw=%0d n=%0d want 1", v, iss_q.size());
                end
            end else if (iss_q.size() != 0) begin
                n_err++;
                $display("FAIL manual_rand_noissue: sw=%0d n=%0d want 0", v, iss_q.size());
            end
            n_vec++;
            if (cur !== m_cur || result !== m_res) begin
                n_err++;
                $display("FAIL manual_rand_state: cur=%0d result=%0d want %0d/%0d",
                         cur, result, m_cur, m_res);
            end
        end
    endtask

    task automatic test_auto();
        logic [W-1:0] a;
        do_reset();
        mode = 2'b01;
        tick(48);
        mode = 2'b11;
        tick(6);
        n_vec++;
        if (iss_q.size() != 6) begin
            n_err++;
            $display("FAIL auto_count: n=%0d want 6", iss_q.size());
        end
        a = '0;
        for (int i = 0; i < 6 && i < iss_q.size(); i++) begin
            a = (a == MX) ? '0 : a + 8'd1;
            n_vec++;
            if (iss_q[i] !== a) begin
                n_err++;
                $display("FAIL auto_arg[%0d]: got %0d want %0d", i, iss_q[i], a);
            end
            if (i > 0) begin
                n_vec++;
                if (iss_cyc[i] - iss_cyc[i-1] != (1 << DW)) begin
                    n_err++;
                    $display("FAIL auto_spacing[%0d]: got %0d want %0d", i,
                             iss_cyc[i] - iss_cyc[i-1], 1 << DW);
                end
            end
        end
        n_vec++;
        if (overrun !== 8'd0) begin
            n_err++;
            $display("FAIL auto_overrun: got %0d want 0", overrun);
        end
    endtask

    task automatic test_auto_stall();
        do_reset();
        in_ready_en = 1'b0;
        mode = 2'b01;
        tick(1);
        for (int i = 0; i < 19; i++) begin
            tick(1);
            n_vec++;
            if (dut_in_valid !== 1'b1 || dut_in !== 8'd1) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: valid=%b in=%0d want 1/1", i, dut_in_valid, dut_in);
            end
        end
        n_vec++;
        if (overrun !== 8'd2) begin
            n_err++;
            $display("FAIL stall_overrun: got %0d want 2", overrun);
        end
        mode = 2'b11;
        in_ready_en = 1'b1;
        tick(6);
        n_vec++;
        if (iss_q.size() != 1 || result !== 8'd2 || overrun !== 8'd2) begin
            n_err++;
            $display("FAIL stall_finish: n=%0d result=%0d ovr=%0d want 1/2/2",
                     iss_q.size(), result, overrun);
        end
    endtask

    task automatic test_step();
        do_reset();
        mode = 2'b10;
        for (int k = 0; k < 3; k++) pulse_step(10);
        n_vec++;
        if (iss_q.size() != 3 || iss_q[0] !== 8'd1 || iss_q[1] !== 8'd2 || iss_q[2] !== 8'd3) begin
            n_err++;
            $display("FAIL step_args: n=%0d want args 1,2,3", iss_q.size());
        end
        n_vec++;
        if (result !== 8'd6 || cur !== 8'd3) begin
            n_err++;
            $display("FAIL step_result: result=%0d cur=%0d want 6/3", result, cur);
        end
        out_en = 1'b0;
        pulse_step(4);
        n_vec++;
        if (dut_out_ready !== 1'b1) begin
            n_err++;
            $display("FAIL step_in_wait: out_ready=%b want 1", dut_out_ready);
        end
        pulse_step(4);
        out_en = 1'b1;
        tick(6);
        n_vec++;
        if (iss_q.size() != 4 || result !== 8'd8 || overrun !== 8'd1) begin
            n_err++;
            $display("FAIL step_drop: n=%0d result=%0d ovr=%0d want 4/8/1",
                     iss_q.size(), result, overrun);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mode = 2'b00;
        out_en = 1'b0;
        sw = 8'd1;
        n = 0;
        while (dut_out_ready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        n_vec++;
        if (dut_out_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_reach_wait: out_ready=%b want 1", dut_out_ready);
        end
        #3;
        rst_n = 1'b0;
        sw = '0;
        #1;
        n_vec++;
        if ({dut_in, dut_in_valid, dut_out_ready, result, cur, overrun} !== '0) begin
            n_err++;
            $display("FAIL midrst_async: outs=%h want 0",
                     {dut_in, dut_in_valid, dut_out_ready, result, cur, overrun});
        end
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        out_en = 1'b1;
        clear_log();
        tick(12);
        n_vec++;
        if (iss_q.size() != 0 || dut_in_valid !== 1'b0 || cur !== 8'd0) begin
            n_err++;
            $display("FAIL midrst_noissue: n=%0d valid=%b cur=%0d want 0/0/0",
                     iss_q.size(), dut_in_valid, cur);
        end
    endtask

    task automatic test_hold();
        int n;
        clear_log();
        mode = 2'b00;
        in_ready_en = 1'b0;
        sw = 8'd3;
        n = 0;
        while (dut_in_valid !== 1'b1 && n < 12) begin
            tick(1);
            n++;
        end
        n_vec++;
        if (dut_in_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_reach_req: valid=%b want 1", dut_in_valid);
        end
        mode = 2'b11;
        tick(2);
        in_ready_en = 1'b1;
        tick(8);
        n_vec++;
        if (iss_q.size() != 1 || result !== 8'd6 || cur !== 8'd3) begin
            n_err++;
            $display("FAIL hold_complete: n=%0d result=%0d cur=%0d want 1/6/3",
                     iss_q.size(), result, cur);
        end
        sw = 8'd1;
        tick(12);
        n_vec++;
        if (iss_q.size() != 1 || dut_in_valid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_quiet: n=%0d valid=%b want 1/0", iss_q.size(), dut_in_valid);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto();
        test_auto_stall();
        test_step();
        test_reset_mid();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
